multi_voice_lfo: RTL and testbench

- N-voice low-frequency modulator for the chorus path; successor to the single-voice chirp source.
- One shared phase accumulator; each voice reads it with an evenly spread phase offset. Per voice: triangle (or optional parabolic sine) shaping, depth scaling, centre offset.
- Emits one value per voice per sample tick, time-multiplexed on a single valid/ready stream that feeds the per-voice delay-line taps.
- Unlike the previous block, config is reloadable at runtime, voice count is parametrised, and frame overruns are reported.

---
 rtl/multi_voice_lfo.sv | 168 ++++++++++++++++
 tb/tb_multi_voice_lfo.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_voice_lfo.sv
// multi_voice_lfo: N-voice low-frequency modulator for the chorus path.
// One shared phase accumulator; voice v reads it at offset v*(2^P/N). Each
// voice is shaped (triangle, or parabolic sine when LFO_SINE_EN is defined),
// scaled by depth, offset by centre and saturated. One value per voice per
// tick is emitted on a single valid/ready stream.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   enable          0 behaves exactly like reset
//   cfg_rate/depth/center, cfg_valid/cfg_ready   config load handshake
//   tick            one-cycle strobe starting a frame
//   dout, dout_voice, dout_last, dout_valid/dout_ready   output stream
//   overrun         sticky: tick seen while a frame was active
//
// Build option: define LFO_SINE_EN for parabolic sine shaping (+1 cycle per voice).
module multi_voice_lfo #(
  parameter int G_NUM_VOICES  = 4,
  parameter int G_PHASE_WIDTH = 24,
  parameter int G_DIN_WIDTH   = 24,
  parameter int G_DOUT_WIDTH  = 24
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [G_DIN_WIDTH-1:0]          cfg_rate,
  input  logic [G_DIN_WIDTH-1:0]          cfg_depth,
  input  logic [G_DIN_WIDTH-1:0]          cfg_center,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic                            tick,
  output logic [G_DOUT_WIDTH-1:0]         dout,
  output logic [$clog2(G_NUM_VOICES):0]   dout_voice,
  output logic                            dout_last,
  output logic                            dout_valid,
  input  logic                            dout_ready,
  output logic                            overrun
);
  localparam int P     = G_PHASE_WIDTH;
  localparam int N     = G_NUM_VOICES;
  localparam int LOG2N = $clog2(N);
  localparam int VW    = LOG2N + 1;
`ifdef LFO_SINE_EN
  localparam int CALC_STAGES = 3;
`else
  localparam int CALC_STAGES = 2;
`endif
  localparam logic [1:0] LAST_STG = 2'(CALC_STAGES - 1);

  typedef enum logic [1:0] {SM_IDLE, SM_WAIT_TICK, SM_CALC, SM_OUT} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_cfg_ready, r_overrun;
  logic [VW-1:0]   r_voice;
  logic [1:0]      r_stg;
  logic [P-1:0]    r_acc, r_rate, r_depth, r_center;
  logic [P-1:0]    r_phase, r_dout;

  logic            w_rst, w_cfg_acc, w_dout_acc, w_calc_done, w_last_voice;
  logic [P-1:0]    w_off;
  logic [P-2:0]    w_u, w_src;
  logic [2*P-2:0]  w_prod;
  logic [P:0]      w_sum;
  logic [P-1:0]    w_sat;

  assign w_rst        = reset | ~enable;
  assign w_cfg_acc    = cfg_valid & r_cfg_ready;
  assign w_dout_acc   = (r_state == SM_OUT) & dout_ready;
  assign w_calc_done  = (r_state == SM_CALC) && (r_stg == LAST_STG);
  assign w_last_voice = (r_voice == VW'(N - 1));

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SM_IDLE:      if (w_cfg_acc) w_state_nxt = SM_WAIT_TICK;
      SM_WAIT_TICK: if (tick) w_state_nxt = SM_CALC;
      SM_CALC:      if (w_calc_done) w_state_nxt = SM_OUT;
      SM_OUT:       if (w_dout_acc) w_state_nxt = w_last_voice ? SM_WAIT_TICK : SM_CALC;
      default:      w_state_nxt = SM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_rst) r_state <= SM_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Control: cfg_ready is registered so it first rises one cycle after reset.
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_cfg_ready <= 1'b0;
      r_overrun   <= 1'b0;
      r_voice     <= '0;
      r_stg       <= '0;
      r_acc       <= '0;
      r_rate      <= '0;
      r_depth     <= '0;
      r_center    <= '0;
    end else begin
      r_cfg_ready <= (w_state_nxt == SM_IDLE) || (w_state_nxt == SM_WAIT_TICK);
      if (w_cfg_acc) begin
        r_rate    <= cfg_rate;
        r_depth   <= cfg_depth;
        r_center  <= cfg_center;
        r_overrun <= 1'b0;
      end else if (tick && ((r_state == SM_CALC) || (r_state == SM_OUT))) begin
        r_overrun <= 1'b1;
      end
      if ((r_state == SM_WAIT_TICK) && tick) begin
        r_voice <= '0;
        r_stg   <= '0;
      end
      if (r_state == SM_CALC) r_stg <= w_calc_done ? 2'd0 : r_stg + 2'd1;
      if (w_dout_acc) begin
        if (w_last_voice) r_acc   <= r_acc + r_rate;
        else              r_voice <= r_voice + VW'(1);
      end
    end
  end

  // Voice phase offset: v * 2^P/N is v placed in the top LOG2N bits.
  assign w_off = P'(r_voice) << (P - LOG2N);

  // Triangle: rising on the lower half-cycle, mirrored on the upper.
  assign w_u = r_phase[P-1] ? ~r_phase[P-2:0] : r_phase[P-2:0];

`ifdef LFO_SINE_EN
  localparam logic [P-2:0] U_MAX = '1;
  logic [P-2:0] r_u, w_u_c, w_shaped;
  logic [2*P:0] w_sq, w_sh;
  // 4*u*(Umax-u) >> (P-1) peaks near Umax; clip guards the rounding edge.
  assign w_u_c    = U_MAX - w_u;
  assign w_sq     = ({(P+2)'(0), w_u} * {(P+2)'(0), w_u_c}) << 2;
  assign w_sh     = w_sq >> (P - 1);
  assign w_shaped = (w_sh > (2*P+1)'(U_MAX)) ? U_MAX : w_sh[P-2:0];
  assign w_src    = r_u;
`else
  assign w_src    = w_u;
`endif

  // depth is a 0..1 fraction with P-1 fractional bits of headroom.
  assign w_prod = {(P-1)'(0), r_depth} * {P'(0), w_src};
  assign w_sum  = {1'b0, r_center} + (P+1)'(w_prod >> (P - 1));
  assign w_sat  = w_sum[P] ? '1 : w_sum[P-1:0];

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_phase <= '0;
      r_dout  <= '0;
`ifdef LFO_SINE_EN
      r_u     <= '0;
`endif
    end else if (r_state == SM_CALC) begin
      if (r_stg == 2'd0) r_phase <= r_acc + w_off;
`ifdef LFO_SINE_EN
      if (r_stg == 2'd1) r_u <= w_shaped;
`endif
      if (r_stg == LAST_STG) r_dout <= w_sat;
    end
  end

  assign cfg_ready  = r_cfg_ready;
  assign dout       = r_dout;
  assign dout_voice = r_voice;
  assign dout_valid = (r_state == SM_OUT);
  assign dout_last  = dout_valid & w_last_voice;
  assign overrun    = r_overrun;
endmodule

// File: tb/tb_multi_voice_lfo.sv
module tb_multi_voice_lfo;
  localparam int N  = 4;
  localparam int P  = 24;
  localparam int VW = 3;
`ifdef LFO_SINE_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1, enable = 1'b1, cfg_valid = 1'b0, tick = 1'b0;
  logic [P-1:0]  cfg_rate = '0, cfg_depth = '0, cfg_center = '0;
  logic          cfg_ready, dout_last, dout_valid, overrun, dout_ready;
  logic [P-1:0]  dout;
  logic [VW-1:0] dout_voice;
  logic          rnd_bp = 1'b0, r_man = 1'b1, r_rnd = 1'b1;

  assign dout_ready = rnd_bp ? r_rnd : r_man;

  always #5 clk = ~clk;

  multi_voice_lfo #(.G_NUM_VOICES(N), .G_PHASE_WIDTH(P), .G_DIN_WIDTH(P), .G_DOUT_WIDTH(P)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .cfg_rate(cfg_rate), .cfg_depth(cfg_depth), .cfg_center(cfg_center),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .tick(tick),
    .dout(dout), .dout_voice(dout_voice), .dout_last(dout_last),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .overrun(overrun)
  );

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Random backpressure source
  always @(posedge clk) begin
    #1 r_rnd = ($urandom_range(0, 3) != 0);
  end

  typedef struct { longint unsigned val; int voice; bit last; int t; } beat_t;
  beat_t exp_q[$];
  beat_t got_q[$];

  // Reference model state
  longint unsigned m_acc = 0, m_rate = 0, m_depth = 0, m_center = 0;
  localparam longint unsigned FULL = 64'd1 << P;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Value of voice v for accumulator acc, straight from the waveform definition.
  function automatic longint unsigned lfo_val(longint unsigned acc, int v,
                                              longint unsigned depth, longint unsigned center);
    longint unsigned half, ph, u, s;
    half = FULL >> 1;
    ph = (acc + 64'(v) * (FULL / N)) % FULL;
    u = (ph < half) ? ph : (FULL - 1 - ph);
`ifdef LFO_SINE_EN
    u = (4 * u * (half - 1 - u)) >> (P - 1);
    if (u > half - 1) u = half - 1;
`endif
    s = center + ((depth * u) >> (P - 1));
    if (s > FULL - 1) s = FULL - 1;
    return s;
  endfunction

  // Compare process: every accepted beat against the scoreboard, every stalled
  // beat must reappear unchanged on the next cycle.
  logic          p_valid = 1'b0, p_ready = 1'b0, p_rst = 1'b1, p_last = 1'b0;
  logic [P-1:0]  p_dout = '0;
  logic [VW-1:0] p_voice = '0;
  always @(negedge clk) begin
    beat_t e, g;
    if (p_valid && !p_ready && !p_rst) begin
      chk("hold_valid", 64'(dout_valid), 64'd1);
      chk("hold_dout", 64'(dout), 64'(p_dout));
      chk("hold_voice", 64'(dout_voice), 64'(p_voice));
      chk("hold_last", 64'(dout_last), 64'(p_last));
    end
    if (dout_valid && dout_ready) begin
      g.val = dout; g.voice = int'(dout_voice); g.last = dout_last; g.t = cyc;
      got_q.push_back(g);
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL extra_beat: got voice %0d value 0x%0h, expected no beat", dout_voice, dout);
      end else begin
        e = exp_q.pop_front();
        chk("beat_dout", 64'(dout), 64'(e.val));
        chk("beat_voice", 64'(dout_voice), 64'(e.voice));
        chk("beat_last", 64'(dout_last), 64'(e.last));
      end
    end
    p_valid = dout_valid; p_ready = dout_ready; p_rst = reset | ~enable;
    p_dout = dout; p_voice = dout_voice; p_last = dout_last;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push_frame();
    beat_t e;
    for (int v = 0; v < N; v++) begin
      e.val = lfo_val(m_acc, v, m_depth, m_center);
      e.voice = v; e.last = (v == N - 1); e.t = 0;
      exp_q.push_back(e);
    end
    m_acc = (m_acc + m_rate) % FULL;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cfg_ready && n < 500) begin step(); n++; end
    if (!cfg_ready) begin
      n_cmp++; n_err++;
      $display("FAIL cfg_ready_timeout: got cfg_ready 0 after %0d cycles, expected 1", n);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin step(); n++; end
    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: got %0d beats pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; r_man = 1'b0; cfg_valid = 1'b0; tick = 1'b0;
    exp_q.delete(); m_acc = 0;
    step();
    reset = 1'b0;
    chk("rst_valid", 64'(dout_valid), 64'd0);
    chk("rst_cfg_ready", 64'(cfg_ready), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_voice", 64'(dout_voice), 64'd0);
    chk("rst_last", 64'(dout_last), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    step();
    chk("rst_cfg_ready_rise", 64'(cfg_ready), 64'd1);
    r_man = 1'b1;
  endtask

  task automatic load_cfg(input logic [P-1:0] rate, input logic [P-1:0] depth,
                          input logic [P-1:0] center, input bit with_tick);
    wait_ready();
    cfg_rate = rate; cfg_depth = depth; cfg_center = center;
    cfg_valid = 1'b1; tick = with_tick;
    m_rate = rate; m_depth = depth; m_center = center;
    if (with_tick) push_frame();
    step();
    cfg_valid = 1'b0; tick = 1'b0;
  endtask

  task automatic do_tick();
    wait_ready();
    tick = 1'b1;
    push_frame();
    step();
    tick = 1'b0;
  endtask

  task automatic wait_beat(input int voice);
    int n = 0;
    while (!(dout_valid && int'(dout_voice) == voice) && n < 100) begin step(); n++; end
    if (!(dout_valid && int'(dout_voice) == voice)) begin
      n_cmp++; n_err++;
      $display("FAIL wait_beat: got no valid beat for voice %0d, expected one", voice);
    end
  endtask

  task automatic chk_got(input string name, input int idx, input longint unsigned val);
    if (idx < got_q.size()) chk(name, 64'(got_q[idx].val), 64'(val));
    else begin
      n_cmp++; n_err++;
      $display("FAIL %s: got no beat %0d, expected 0x%0h", name, idx, val);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    step(); step();
    do_reset();

    // 1: basic frame, latency, voice/last tagging
    load_cfg(24'h0, 24'h800000, 24'h100000, 1'b0);
    base = got_q.size();
    do_tick();
    n = 0;
    while (!dout_valid && n < 20) begin step(); n++; end
    chk("first_latency", 64'(n + 1), 64'(LAT));
    wait_drain();
`ifndef LFO_SINE_EN
    chk_got("t1_v0", base + 0, 64'h100000);
    chk_got("t1_v1", base + 1, 64'h500000);
    chk_got("t1_v2", base + 2, 64'h8FFFFF);
    chk_got("t1_v3", base + 3, 64'h4FFFFF);
`endif
    if (got_q.size() >= base + 4) begin
      chk("t1_last_v2", 64'(got_q[base + 2].last), 64'd0);
      chk("t1_last_v3", 64'(got_q[base + 3].last), 64'd1);
      chk("voice_spacing", 64'(got_q[base + 1].t - got_q[base].t), 64'(LAT));
    end

    // 3: backpressure on voice 1
    base = got_q.size();
    do_tick();
    wait_beat(1);
    r_man = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_valid", 64'(dout_valid), 64'd1);
    end
`ifndef LFO_SINE_EN
    chk("bp_dout", 64'(dout), 64'h500000);
`endif
    r_man = 1'b1;
    wait_drain();
    chk("bp_beats", 64'(got_q.size() - base), 64'd4);

    // 2: accumulator advance and wrap
    load_cfg(24'h400000, 24'h800000, 24'h100000, 1'b0);
    base = got_q.size();
    for (int f = 0; f < 5; f++) begin do_tick(); wait_drain(); end
`ifndef LFO_SINE_EN
    chk_got("wrap_f0", base + 0, 64'h100000);
    chk_got("wrap_f1", base + 4, 64'h500000);
    chk_got("wrap_f2", base + 8, 64'h8FFFFF);
    chk_got("wrap_f3", base + 12, 64'h4FFFFF);
    chk_got("wrap_f4", base + 16, 64'h100000);
`endif

    // 4: saturation
    do_reset();
    load_cfg(24'h0, 24'hFFFFFF, 24'hF00000, 1'b0);
    base = got_q.size();
    do_tick(); wait_drain();
    chk_got("sat_v0", base + 0, 64'hF00000);
    chk_got("sat_v2", base + 2, 64'hFFFFFF);

    // 5: overrun
    base = got_q.size();
    do_tick();
    chk("ovr_before", 64'(overrun), 64'd0);
    step();
    tick = 1'b1; step(); tick = 1'b0;
    chk("ovr_set", 64'(overrun), 64'd1);
    wait_drain();
    repeat (8) step();
    chk("ovr_beats", 64'(got_q.size() - base), 64'd4);
    chk("ovr_sticky", 64'(overrun), 64'd1);
    load_cfg(24'h400000, 24'h800000, 24'h100000, 1'b0);
    chk("ovr_clear", 64'(overrun), 64'd0);

    // 6: reset during voice 2 output
    do_tick(); wait_drain();
    base = got_q.size();
    do_tick();
    wait_beat(2);
    reset = 1'b1; r_man = 1'b0; exp_q.delete(); m_acc = 0;
    step();
    reset = 1'b0;
    chk("midrst_valid", 64'(dout_valid), 64'd0);
    chk("midrst_cfg_ready", 64'(cfg_ready), 64'd0);
    step();
    chk("midrst_cfg_ready_rise", 64'(cfg_ready), 64'd1);
    r_man = 1'b1;
    repeat (10) step();
    chk("midrst_beats", 64'(got_q.size() - base), 64'd2);
    load_cfg(24'h400000, 24'h800000, 24'h100000, 1'b0);
    base = got_q.size();
    do_tick(); wait_drain();
    chk_got("midrst_v0", base, 64'h100000);

    // enable low behaves as reset
    do_tick();
    wait_beat(0);
    enable = 1'b0; r_man = 1'b0; exp_q.delete(); m_acc = 0;
    step();
    enable = 1'b1;
    chk("en_valid", 64'(dout_valid), 64'd0);
    chk("en_cfg_ready", 64'(cfg_ready), 64'd0);
    step();
    chk("en_cfg_ready_rise", 64'(cfg_ready), 64'd1);
    r_man = 1'b1;

    // Randomized frames with random backpressure and runtime cfg changes
    load_cfg(24'($urandom), 24'($urandom), 24'($urandom), 1'b0);
    rnd_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: load_cfg(24'($urandom), 24'($urandom), 24'($urandom_range(0, 24'hFFFFFF)), 1'b0);
        1: load_cfg(24'($urandom), 24'($urandom), 24'($urandom), 1'b1);
        default: do_tick();
      endcase
      repeat ($urandom_range(0, 15)) step();
    end
    wait_drain();
    rnd_bp = 1'b0;
    chk("rnd_overrun", 64'(overrun), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
